// File: rtl/ppu_pkg.sv
// ppu_pkg: posit width helpers (kw/fw/sw/ew), decoded-posit struct, NaR/zero constants of N
package ppu_pkg;
    localparam int PPU_MAX_N  = 32;
    localparam int PPU_MAX_ES = 4;
    function automatic int kw(input int n);
        return $clog2(n) + 1;
    endfunction
    function automatic int fw(input int n, input int es);
        return n - 3 - es;
    endfunction
    function automatic int sw(input int n, input int es);
        return kw(n) + es;
    endfunction
    function automatic int ew(input int es);
        return es > 0 ? es : 1;
    endfunction
    function automatic logic [63:0] nar_val(input int n);
        return 64'd1 << (n - 1);
    endfunction
    function automatic logic [63:0] zero_val(input int n);
        return 64'd0 << n;
    endfunction
    typedef struct packed {
        logic                                          sign;
        logic signed [kw(PPU_MAX_N)-1:0]               k;
        logic [PPU_MAX_ES-1:0]                         exp;
        logic [fw(PPU_MAX_N, 0)-1:0]                   frac;
        logic signed [sw(PPU_MAX_N, PPU_MAX_ES)-1:0]   scale;
        logic                                          is_zero;
        logic                                          is_nar;
    } posit_dec_t;
endpackage

// File: rtl/lzc.sv
// lzc: leading-zero counter; in_bits[WIDTH] -> count[CW] (WIDTH when all zero)
module lzc #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] in_bits,
    output logic [CW-1:0]    count
);
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++)
            if (in_bits[i]) count = CW'(WIDTH - 1 - i);
    end
endmodule

// File: rtl/posit_decode_pipe.sv
// posit_decode_pipe: 2-stage posit<N,ES> decoder; in_valid/in_ready/in_posit -> out_valid/out_ready/out_sign/out_k/out_exp/out_frac/out_scale/out_is_zero/out_is_nar; in_tag/out_tag with POSIT_DECODE_TAG_EN
module posit_decode_pipe
    import ppu_pkg::*;
#(
    parameter int N  = 16,
    parameter int ES = 1
`ifdef POSIT_DECODE_TAG_EN
    , parameter int TAG_W = 4
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_posit,
`ifdef POSIT_DECODE_TAG_EN
    input  logic [TAG_W-1:0]     in_tag,
    output logic [TAG_W-1:0]     out_tag,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic [kw(N)-1:0]     out_k,
    output logic [ew(ES)-1:0]    out_exp,
    output logic [fw(N, ES)-1:0] out_frac,
    output logic [sw(N, ES)-1:0] out_scale,
    output logic                 out_is_zero,
    output logic                 out_is_nar
);
    localparam int KW = kw(N);
    localparam int FW = fw(N, ES);
    localparam int SW = sw(N, ES);
    localparam int EW = ew(ES);
    localparam int MW = $clog2(N);
    localparam logic [N-1:0] NAR  = N'(nar_val(N));
    localparam logic [N-1:0] ZERO = N'(zero_val(N));
    logic s2_adv, s1_adv, in_fire, ld2, special;
    logic [N-2:0] body, lzc_in;
    logic [MW-1:0] run, rl;
    logic [N-4:0] rem;
    logic signed [KW-1:0] k;
    logic [EW-1:0] ex;
    logic [SW-1:0] scale;
    logic s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d, s1_pol_q, s1_pol_d;
    logic s1_zero_q, s1_zero_d, s1_nar_q, s1_nar_d;
    logic [N-2:0] s1_body_q, s1_body_d;
    logic [MW-1:0] s1_m_q, s1_m_d;
    logic out_valid_q, out_valid_d, out_sign_q, out_sign_d;
    logic out_is_zero_q, out_is_zero_d, out_is_nar_q, out_is_nar_d;
    logic [KW-1:0] out_k_q, out_k_d;
    logic [EW-1:0] out_exp_q, out_exp_d;
    logic [FW-1:0] out_frac_q, out_frac_d;
    logic [SW-1:0] out_scale_q, out_scale_d;
`ifdef POSIT_DECODE_TAG_EN
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d, out_tag_q, out_tag_d;
    assign out_tag = out_tag_q;
`endif
    // low bits of -p depend only on low bits of p, so the body is negated at N-1 bits
    assign body   = in_posit[N-1] ? ~in_posit[N-2:0] + 1'b1 : in_posit[N-2:0];
    // invert a ones-run so the counter always measures a zeros-run
    assign lzc_in = body[N-2] ? ~body : body;
    lzc #(.WIDTH(N - 1), .CW(MW)) u_lzc (.in_bits(lzc_in), .count(run));
    always_comb begin
        s2_adv     = !out_valid_q || out_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        in_fire    = in_valid && s1_adv;
        s1_valid_d = s1_adv ? in_valid : s1_valid_q;
        s1_sign_d  = in_fire ? in_posit[N-1] : s1_sign_q;
        s1_body_d  = in_fire ? body : s1_body_q;
        s1_m_d     = in_fire ? run : s1_m_q;
        s1_pol_d   = in_fire ? body[N-2] : s1_pol_q;
        s1_zero_d  = in_fire ? in_posit == ZERO : s1_zero_q;
        s1_nar_d   = in_fire ? in_posit == NAR : s1_nar_q;
`ifdef POSIT_DECODE_TAG_EN
        s1_tag_d   = in_fire ? in_tag : s1_tag_q;
`endif
    end
    always_comb begin
        // a full-length run has no terminating bit
        rl      = (s1_m_q == MW'(N - 1)) ? s1_m_q : s1_m_q + 1'b1;
        // after the regime shift the bottom two bits are always zero; drop them
        rem     = (N - 3)'((s1_body_q << rl) >> 2);
        k       = s1_pol_q ? KW'(s1_m_q) - 1'b1 : -KW'(s1_m_q);
        scale   = (SW'(k) <<< ES) + SW'(ex);
        special = s1_zero_q || s1_nar_q;
        ld2     = s2_adv && s1_valid_q;
        out_valid_d   = s2_adv ? s1_valid_q : out_valid_q;
        out_sign_d    = ld2 ? s1_sign_q : out_sign_q;
        out_is_zero_d = ld2 ? s1_zero_q : out_is_zero_q;
        out_is_nar_d  = ld2 ? s1_nar_q : out_is_nar_q;
        out_k_d       = !ld2 ? out_k_q : special ? '0 : k;
        out_exp_d     = !ld2 ? out_exp_q : special ? '0 : ex;
        out_frac_d    = !ld2 ? out_frac_q : special ? '0 : rem[FW-1:0];
        out_scale_d   = !ld2 ? out_scale_q : special ? '0 : scale;
`ifdef POSIT_DECODE_TAG_EN
        out_tag_d     = ld2 ? s1_tag_q : out_tag_q;
`endif
    end
    if (ES > 0) begin : g_exp
        assign ex = rem[N-4 -: ES];
    end else begin : g_noexp
        assign ex = '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_body_q     <= '0;
            s1_m_q        <= '0;
            s1_pol_q      <= 1'b0;
            s1_zero_q     <= 1'b0;
            s1_nar_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            out_sign_q    <= 1'b0;
            out_is_zero_q <= 1'b0;
            out_is_nar_q  <= 1'b0;
            out_k_q       <= '0;
            out_exp_q     <= '0;
            out_frac_q    <= '0;
            out_scale_q   <= '0;
`ifdef POSIT_DECODE_TAG_EN
            s1_tag_q      <= '0;
            out_tag_q     <= '0;
`endif
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_sign_q     <= s1_sign_d;
            s1_body_q     <= s1_body_d;
            s1_m_q        <= s1_m_d;
            s1_pol_q      <= s1_pol_d;
            s1_zero_q     <= s1_zero_d;
            s1_nar_q      <= s1_nar_d;
            out_valid_q   <= out_valid_d;
            out_sign_q    <= out_sign_d;
            out_is_zero_q <= out_is_zero_d;
            out_is_nar_q  <= out_is_nar_d;
            out_k_q       <= out_k_d;
            out_exp_q     <= out_exp_d;
            out_frac_q    <= out_frac_d;
            out_scale_q   <= out_scale_d;
`ifdef POSIT_DECODE_TAG_EN
            s1_tag_q      <= s1_tag_d;
            out_tag_q     <= out_tag_d;
`endif
        end
    end
    assign in_ready    = s1_adv;
    assign out_valid   = out_valid_q;
    assign out_sign    = out_sign_q;
    assign out_k       = out_k_q;
    assign out_exp     = out_exp_q;
    assign out_frac    = out_frac_q;
    assign out_scale   = out_scale_q;
    assign out_is_zero = out_is_zero_q;
    assign out_is_nar  = out_is_nar_q;
endmodule

// File: tb/tb_posit_decode_pipe.sv
// tb_posit_decode_pipe: directed + randomized checks of posit_decode_pipe (N=16/ES=1 and N=8/ES=0) against a bit-walking posit model
module tb_posit_decode_pipe;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready, out_sign, out_is_zero, out_is_nar;
    logic [15:0] in_posit;
    logic [4:0] out_k;
    logic [0:0] out_exp;
    logic [11:0] out_frac;
    logic [5:0] out_scale;
    logic in_valid8, in_ready8, out_valid8, out_sign8, out_is_zero8, out_is_nar8;
    logic [7:0] in_posit8;
    logic [3:0] out_k8;
    logic [0:0] out_exp8;
    logic [4:0] out_frac8;
    logic [3:0] out_scale8;
`ifdef POSIT_DECODE_TAG_EN
    logic [3:0] in_tag, out_tag, in_tag8, out_tag8;
`endif
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    posit_decode_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_posit(in_posit),
`ifdef POSIT_DECODE_TAG_EN
        .in_tag(in_tag), .out_tag(out_tag),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_k(out_k),
        .out_exp(out_exp), .out_frac(out_frac), .out_scale(out_scale),
        .out_is_zero(out_is_zero), .out_is_nar(out_is_nar));
    posit_decode_pipe #(.N(8), .ES(0)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_posit(in_posit8),
`ifdef POSIT_DECODE_TAG_EN
        .in_tag(in_tag8), .out_tag(out_tag8),
`endif
        .out_valid(out_valid8), .out_ready(1'b1), .out_sign(out_sign8), .out_k(out_k8),
        .out_exp(out_exp8), .out_frac(out_frac8), .out_scale(out_scale8),
        .out_is_zero(out_is_zero8), .out_is_nar(out_is_nar8));
    typedef struct { int sign; int k; int ex; int frac; int scale; int z; int nar; } dec_t;
    // walks the posit bit by bit: regime run, terminator, exponent, fraction; bits past the end read 0
    function automatic dec_t model(int n, int es, longint unsigned p);
        dec_t d = '{default: 0};
        longint unsigned a;
        int pos, m, r0;
        if (p == 0) begin
            d.z = 1;
            return d;
        end
        if (p == (64'd1 << (n - 1))) begin
            d.nar = 1;
            d.sign = 1;
            return d;
        end
        d.sign = int'(p >> (n - 1)) & 1;
        a = d.sign ? ((64'd1 << n) - p) : p;
        r0 = int'(a >> (n - 2)) & 1;
        m = 0;
        pos = n - 2;
        while (pos >= 0 && (int'(a >> pos) & 1) == r0) begin
            m++;
            pos--;
        end
        d.k = r0 ? m - 1 : -m;
        pos--;
        for (int i = 0; i < es; i++) begin
            d.ex = d.ex * 2 + (pos >= 0 ? int'(a >> pos) & 1 : 0);
            pos--;
        end
        for (int i = 0; i < n - 3 - es; i++) begin
            d.frac = d.frac * 2 + (pos >= 0 ? int'(a >> pos) & 1 : 0);
            pos--;
        end
        d.scale = d.k * (1 << es) + d.ex;
        return d;
    endfunction
    task automatic chk(string tag, longint obs, longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic chk16(string t, dec_t e);
        chk({t, ".sign"}, longint'(out_sign), e.sign);
        chk({t, ".k"}, longint'($signed(out_k)), e.k);
        chk({t, ".exp"}, longint'(out_exp), e.ex);
        chk({t, ".frac"}, longint'(out_frac), e.frac);
        chk({t, ".scale"}, longint'($signed(out_scale)), e.scale);
        chk({t, ".zero"}, longint'(out_is_zero), e.z);
        chk({t, ".nar"}, longint'(out_is_nar), e.nar);
    endtask
    task automatic chk8(string t, dec_t e);
        chk({t, ".sign"}, longint'(out_sign8), e.sign);
        chk({t, ".k"}, longint'($signed(out_k8)), e.k);
        chk({t, ".exp"}, longint'(out_exp8), 0);
        chk({t, ".frac"}, longint'(out_frac8), e.frac);
        chk({t, ".scale"}, longint'($signed(out_scale8)), e.scale);
        chk({t, ".zero"}, longint'(out_is_zero8), e.z);
        chk({t, ".nar"}, longint'(out_is_nar8), e.nar);
    endtask
    // one word through with out_ready high: idle after 1 edge, valid after exactly 2
    task automatic send16(input logic [15:0] p, input string t);
        in_valid = 1'b1;
        in_posit = p;
        out_ready = 1'b1;
        #1 chk({t, ".in_ready"}, longint'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk({t, ".lat1_valid"}, longint'(out_valid), 0);
        @(negedge clk);
        #1 chk({t, ".lat2_valid"}, longint'(out_valid), 1);
        chk16(t, model(16, 1, p));
    endtask
    task automatic send8(input logic [7:0] p, input string t);
        in_valid8 = 1'b1;
        in_posit8 = p;
        @(negedge clk);
        in_valid8 = 1'b0;
        @(negedge clk);
        #1 chk({t, ".valid"}, longint'(out_valid8), 1);
        chk8(t, model(8, 0, p));
    endtask
    function automatic logic [15:0] rnd16();
        int s = $urandom_range(0, 9);
        return s == 0 ? 16'h0000 : s == 1 ? 16'h8000 : s == 2 ? 16'h0001 : s == 3 ? 16'h7FFF : 16'($urandom);
    endfunction
    initial begin
        logic [15:0] w [4] = '{16'h4000, 16'h5A00, 16'h7FFF, 16'h0001};
        longint unsigned q_p [$];
        int q_t [$];
        int idx, oidx;
        rst = 1'b1;
        in_valid = 1'b0;
        in_posit = '0;
        out_ready = 1'b1;
        in_valid8 = 1'b0;
        in_posit8 = '0;
`ifdef POSIT_DECODE_TAG_EN
        in_tag = '0;
        in_tag8 = '0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 chk("reset.out_valid", longint'(out_valid), 0);
        chk("reset.in_ready", longint'(in_ready), 1);
        chk("reset.k", longint'(out_k), 0);
        chk("reset.scale", longint'(out_scale), 0);
`ifdef POSIT_DECODE_TAG_EN
        chk("reset.tag", longint'(out_tag), 0);
`endif
        send16(16'h4000, "d4000");
        send16(16'h5A00, "d5A00");
        chk("d5A00.frac_const", longint'(out_frac), 'hA00);
        chk("d5A00.scale_const", longint'($signed(out_scale)), 1);
        send16(16'hC000, "dC000");
        chk("dC000.sign_const", longint'(out_sign), 1);
        send16(16'h0001, "d0001");
        chk("d0001.k_const", longint'($signed(out_k)), -14);
        chk("d0001.scale_const", longint'($signed(out_scale)), -28);
        send16(16'h7FFF, "d7FFF");
        chk("d7FFF.k_const", longint'($signed(out_k)), 14);
        chk("d7FFF.scale_const", longint'($signed(out_scale)), 28);
        send16(16'h0000, "d0000");
        chk("d0000.zero_const", longint'(out_is_zero), 1);
        send16(16'h8000, "d8000");
        chk("d8000.nar_const", longint'(out_is_nar), 1);
        @(negedge clk);
        // backpressure: out_ready low for 3 cycles while 4 words are offered back-to-back
        idx = 0;
        oidx = 0;
        for (int c = 0; c < 40 && oidx < 4; c++) begin
            in_valid = idx < 4;
            in_posit = w[idx % 4];
            out_ready = c >= 3;
`ifdef POSIT_DECODE_TAG_EN
            in_tag = 4'(idx + 1);
`endif
            #1;
            if (idx == 2 && !out_ready) chk("bp.in_ready_low", longint'(in_ready), 0);
            if (out_valid) begin
                chk16($sformatf("bp.w%0d", oidx), model(16, 1, w[oidx]));
`ifdef POSIT_DECODE_TAG_EN
                chk("bp.tag", longint'(out_tag), oidx + 1);
`endif
                if (out_ready) oidx++;
            end
            if (in_valid && in_ready) idx++;
            @(negedge clk);
        end
        chk("bp.all_out", oidx, 4);
        in_valid = 1'b0;
        // reset flush with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_posit = 16'h5A00;
        repeat (2) @(negedge clk);
        #1 chk("flush.pre_full", longint'(out_valid && !in_ready), 1);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("flush.out_valid", longint'(out_valid), 0);
        chk("flush.in_ready", longint'(in_ready), 1);
        chk("flush.frac", longint'(out_frac), 0);
        chk("flush.sign", longint'(out_sign), 0);
        chk("flush.k", longint'(out_k), 0);
        @(negedge clk);
        out_ready = 1'b1;
        #1 chk("flush.no_ghost", longint'(out_valid), 0);
        @(negedge clk);
        // randomized traffic against an in-order scoreboard
        for (int c = 0; c < 400; c++) begin
            in_valid = (c < 300) && ($urandom_range(0, 3) != 0);
            in_posit = rnd16();
            out_ready = (c >= 300) || ($urandom_range(0, 2) != 0);
`ifdef POSIT_DECODE_TAG_EN
            in_tag = 4'($urandom);
`endif
            #1;
            chk("rnd.unexpected_valid", longint'(out_valid && q_p.size() == 0), 0);
            if (out_valid && q_p.size() != 0) begin
                chk16("rnd", model(16, 1, q_p[0]));
`ifdef POSIT_DECODE_TAG_EN
                chk("rnd.tag", longint'(out_tag), q_t[0]);
`endif
                if (out_ready) begin
                    void'(q_p.pop_front());
                    void'(q_t.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                q_p.push_back(in_posit);
`ifdef POSIT_DECODE_TAG_EN
                q_t.push_back(int'(in_tag));
`else
                q_t.push_back(0);
`endif
            end
            @(negedge clk);
        end
        chk("rnd.drained", q_p.size(), 0);
        in_valid = 1'b0;
        send8(8'h07, "n8_07");
        chk("n8_07.k_const", longint'($signed(out_k8)), -4);
        chk("n8_07.frac_const", longint'(out_frac8), 'b11000);
        send8(8'h80, "n8_80");
        send8(8'h7F, "n8_7F");
        for (int i = 0; i < 30; i++) send8(8'($urandom), $sformatf("n8_r%0d", i));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/posit_decode_pipe.md
# posit_decode_pipe

Parametrised, pipelined posit decoder that splits a posit⟨N,ES⟩ word into sign, regime value k, exponent, left-aligned fraction, combined scale and special-case flags. It generalises the fixed 8-bit, ES=0 combinational decoder to arbitrary N/ES. It adds a two-stage registered pipeline with valid/ready flow control, so it can sit directly between the operand FIFOs and the PPU arithmetic core at one decode per cycle.

## Interface
- N, 16, posit width in bits; N ≥ ES+4
- ES, 1, exponent field width; 0 allowed
- TAG_W, 4, sideband tag width; used only with POSIT_DECODE_TAG_EN
- Derived (package functions, not parameters): KW = $clog2(N)+1 (signed k width), FW = N-3-ES (fraction width), SW = KW+ES (signed scale width)
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept in_posit this cycle
- in_posit  in  N  posit word, two's-complement encoded
- out_valid  out  1  decoded result valid
- out_ready  in  1  consumer accepts result this cycle
- out_sign  out  1  posit sign bit
- out_k  out  KW  signed regime value
- out_exp  out  max(ES,1)  exponent field; tied 0 when ES=0
- out_frac  out  FW  fraction bits, MSB-aligned, hidden bit excluded
- out_scale  out  SW  signed k·2^ES + exp
- out_is_zero  out  1  input was all zeros
- out_is_nar  out  1  input was 1 followed by N-1 zeros
- in_tag / out_tag  in/out  TAG_W  sideband tag; present only with POSIT_DECODE_TAG_EN

## Operation
- Transfer occurs on a cycle where valid && ready; otherwise no transfer.
- Stage 1 (S1), captured on input transfer:
  - sign = p[N-1]
  - abs = sign ? -p : p (N-bit two's complement)
  - body = abs[N-2:0]
  - is_zero = (p==0); is_nar = (p == 1<<(N-1))
  - run length m = number of leading bits of body equal to body[N-2]; 1 ≤ m ≤ N-1
  - Registered: sign, body, m, polarity, flags
- Stage 2 (S2), output registers:
  - k = polarity ? m-1 : -m
  - reg_len = min(m+1, N-1)
  - rem = body << reg_len (N-1 bits, zero-filled)
  - exp = rem[N-2 -: ES]; frac = rem[N-2-ES -: FW]
  - scale = (k <<< ES) + exp; sign-extended, no overflow possible by width choice
- Specials: when is_zero or is_nar, k, exp, frac and scale are forced to 0. out_sign is 0 for zero and 1 for NaR.
- Truncated fields (regime consuming exponent bits) read as zeros; no rounding.

## Timing
- Latency: 2 cycles from input transfer to out_valid; throughput 1 word/cycle with out_ready held high.
- s2_adv = !out_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv (combinational from out_ready, no input register path).
- All out_* data are registered and held stable while out_valid && !out_ready.
- No bubbles under continuous backpressure release; results are never dropped, duplicated or reordered.
- Reset: out_valid=0, internal s1_valid=0, all out_* data 0, out_tag 0. in_ready=1 in the first cycle after rst deasserts.
- rst asserted mid-stream flushes both stages in one cycle; words in flight are discarded.
- Simultaneous output transfer and input transfer with both stages full is legal and keeps full occupancy.

## Configuration
- POSIT_DECODE_TAG_EN defined: the in_tag/out_tag ports exist, and the tag travels through S1/S2 aligned with its word under the same stall rules.
- Undefined: the ports and registers are absent; all other behaviour is identical.

## Structure
- ppu_pkg holds the KW/FW/SW width functions, the decoded-posit struct typedef (sign, k, exp, frac, scale, is_zero, is_nar) and the NaR/zero constant functions of N.
- One sub-module: lzc, a parametrised leading-zero counter (WIDTH, output count). S1 feeds it body or ~body depending on polarity.

## Test plan (N=16, ES=1 unless noted)
- 0x4000 -> sign 0, k 0, exp 0, frac 0x000, scale 0, flags 0; out_valid exactly 2 cycles after transfer.
- 0x5A00 -> k 0, exp 1, frac 0xA00, scale 1; 0xC000 -> sign 1, k 0, scale 0.
- 0x0001 -> k -14, exp 0, frac 0, scale -28; 0x7FFF -> k 14, scale 28 (reg_len clamps at 15).
- 0x0000 -> is_zero 1, all fields 0; 0x8000 -> is_nar 1, sign 1, fields 0.
- Backpressure: feed 0x4000, 0x5A00, 0x7FFF, 0x0001 back-to-back with out_ready=0 for 3 cycles. in_ready drops after two words are captured, and all four emerge in order with stable data. With POSIT_DECODE_TAG_EN, tags 1..4 match their words.
- rst pulsed while both stages are full -> next cycle out_valid 0, outputs 0, in_ready 1; N=8, ES=0 regression: 0x07 -> k -4, frac 0b11000 (FW=5).
